// File: rtl/cipher_pkg.sv
// Shared cipher-datapath definitions: symbol width, symbol type and table-load ids.
package cipher_pkg;

  localparam int unsigned SYM_W     = 6;
  localparam int unsigned TBL_DEPTH = 2 ** SYM_W;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [1:0] {
    TBL_ROTOR_A   = 2'b00,
    TBL_ROTOR_B   = 2'b01,
    TBL_PLUGBOARD = 2'b10,
    TBL_REFLECTOR = 2'b11
  } tbl_id_e;

endpackage

// File: rtl/rotor_b_if.sv
// Rotor-B symbol/load bus; slave is the rotor, master is whoever drives it.
interface rotor_b_if;
  import cipher_pkg::*;

  logic       load;
  logic [1:0] table_idx;
  sym_t       code_in;
  logic       encrypt;
  sym_t       rotorA_forward_out;
  sym_t       plugboard_backward_out;
  logic [1:0] rotorB_shift_mode;
  sym_t       rotorB_forward_out;
  sym_t       rotorB_backward_out;
  logic       table_ready;

  modport slave (
    input  load, table_idx, code_in, encrypt,
    input  rotorA_forward_out, plugboard_backward_out, rotorB_shift_mode,
    output rotorB_forward_out, rotorB_backward_out, table_ready
  );

  modport master (
    output load, table_idx, code_in, encrypt,
    output rotorA_forward_out, plugboard_backward_out, rotorB_shift_mode,
    input  rotorB_forward_out, rotorB_backward_out, table_ready
  );

endinterface

// File: rtl/rotor_perm_table.sv
// 64-entry forward/inverse permutation pair with identity reset, one write port
// and two combinational read ports.
module rotor_perm_table
  import cipher_pkg::*;
(
  input  logic clk,
  input  logic srst_n,
  input  logic we,
  input  sym_t widx,
  input  sym_t wval,
  input  sym_t fwd_addr,
  input  sym_t inv_addr,
  output sym_t fwd_data,
  output sym_t inv_data
);

  sym_t fwd [TBL_DEPTH];
  sym_t inv [TBL_DEPTH];

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
        fwd[i] <= sym_t'(i);
        inv[i] <= sym_t'(i);
      end
    end else if (we) begin
      fwd[widx] <= wval;
      inv[wval] <= widx;
    end
  end

  assign fwd_data = fwd[fwd_addr];
  assign inv_data = inv[inv_addr];

endmodule

// File: rtl/rotor_b.sv
// Second cipher rotor: rotating-offset permutation forward, inverse backward,
// with a sequential table loader and plugboard-driven rotation.
module rotor_b #(
  parameter int unsigned SYM_W  = 6,
  parameter logic [1:0]  TBL_ID = 2'b01
) (
  input logic      clk,
  input logic      srst_n,
  rotor_b_if.slave bus
);
  import cipher_pkg::*;

  logic [SYM_W-1:0] offset;
  logic [SYM_W-1:0] load_cnt;
  logic             ready;
  logic             load_hit;
  sym_t             fwd_data;
  sym_t             inv_data;

  assign load_hit = bus.load && (bus.table_idx == TBL_ID);

  // A load cycle always wins over rotation and re-zeroes the offset.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      offset   <= '0;
      load_cnt <= '0;
      ready    <= 1'b1;
    end else if (load_hit) begin
      offset   <= '0;
      load_cnt <= load_cnt + 1'b1;
      ready    <= &load_cnt;
    end else if (bus.encrypt) begin
      offset   <= offset + {{(SYM_W-2){1'b0}}, bus.rotorB_shift_mode};
    end
  end

  rotor_perm_table u_table (
    .clk      (clk),
    .srst_n   (srst_n),
    .we       (load_hit),
    .widx     (load_cnt),
    .wval     (bus.code_in),
    .fwd_addr (bus.rotorA_forward_out + offset),
    .inv_addr (bus.plugboard_backward_out),
    .fwd_data (fwd_data),
    .inv_data (inv_data)
  );

  assign bus.rotorB_forward_out  = bus.encrypt ? fwd_data : '0;
  assign bus.rotorB_backward_out = inv_data - offset;
  assign bus.table_ready         = ready;

endmodule

// File: tb/tb_rotor_b.sv
// Bench for rotor_b: per-cycle comparison against an array model plus directed literals.
module tb_rotor_b;

  logic clk = 1'b0;
  logic srst_n;
  always #5 clk = ~clk;

  rotor_b_if bus ();

  rotor_b #(.SYM_W(6), .TBL_ID(2'b01)) dut (
    .clk    (clk),
    .srst_n (srst_n),
    .bus    (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  int m_fwd [64];
  int m_inv [64];
  int m_off;
  int m_cnt;
  int m_ready;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model of the rotor state, advanced on every rising edge.
  always @(posedge clk) begin
    if (!srst_n) begin
      for (int i = 0; i < 64; i++) begin
        m_fwd[i] = i;
        m_inv[i] = i;
      end
      m_off = 0; m_cnt = 0; m_ready = 1;
    end else if (bus.load && bus.table_idx == 2'b01) begin
      m_fwd[m_cnt] = int'(bus.code_in);
      m_inv[int'(bus.code_in)] = m_cnt;
      m_ready = (m_cnt == 63) ? 1 : 0;
      m_cnt = (m_cnt + 1) % 64;
      m_off = 0;
    end else if (bus.encrypt) begin
      m_off = (m_off + int'(bus.rotorB_shift_mode)) % 64;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int ef, eb;
      ef = bus.encrypt ? m_fwd[(int'(bus.rotorA_forward_out) + m_off) % 64] : 0;
      eb = (m_inv[int'(bus.plugboard_backward_out)] - m_off + 64) % 64;
      check("model_fwd", int'(bus.rotorB_forward_out), ef);
      check("model_bwd", int'(bus.rotorB_backward_out), eb);
      check("model_ready", int'(bus.table_ready), m_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sym(input int a, input int b, input bit enc, input int sh);
    bus.rotorA_forward_out     = 6'(a);
    bus.plugboard_backward_out = 6'(b);
    bus.encrypt                = enc;
    bus.rotorB_shift_mode      = 2'(sh);
  endtask

  task automatic do_reset();
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    srst_n        = 1'b0;
    bus.load      = 1'b0;
    bus.table_idx = 2'b00;
    bus.code_in   = '0;
    set_sym(0, 0, 1'b0, 0);
    tick();
    tick();
    srst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state: identity tables
    set_sym(5, 9, 1'b1, 0);
    @(negedge clk);
    check("rst_fwd5", int'(bus.rotorB_forward_out), 5);
    check("rst_bwd9", int'(bus.rotorB_backward_out), 9);
    check("rst_ready", int'(bus.table_ready), 1);

    // Full load of (i+1)%64
    set_sym(0, 0, 1'b0, 0);
    for (int i = 0; i < 64; i++) begin
      bus.load = 1'b1; bus.table_idx = 2'b01; bus.code_in = 6'((i + 1) % 64);
      tick();
      @(negedge clk);
      if (i == 0)  check("load_ready_first", int'(bus.table_ready), 0);
      if (i == 62) check("load_ready_62", int'(bus.table_ready), 0);
      if (i == 63) check("load_ready_done", int'(bus.table_ready), 1);
    end
    bus.load = 1'b0;
    set_sym(5, 6, 1'b1, 0);
    @(negedge clk);
    check("tbl_fwd5", int'(bus.rotorB_forward_out), 6);
    check("tbl_bwd6", int'(bus.rotorB_backward_out), 5);

    // Three rotations of 2 -> offset 6
    bus.rotorB_shift_mode = 2'd2;
    repeat (3) tick();
    set_sym(5, 12, 1'b1, 0);
    @(negedge clk);
    check("rot6_fwd5", int'(bus.rotorB_forward_out), 12);
    check("rot6_bwd12", int'(bus.rotorB_backward_out), 5);

    // Offset wrap on identity table: 62 + 3 -> 1
    do_reset();
    set_sym(0, 0, 1'b1, 3);
    repeat (20) tick();
    bus.rotorB_shift_mode = 2'd2;
    tick();
    set_sym(2, 0, 1'b1, 0);
    @(negedge clk);
    check("off62_fwd2", int'(bus.rotorB_forward_out), 0);
    check("off62_bwd0", int'(bus.rotorB_backward_out), 2);
    bus.rotorB_shift_mode = 2'd3;
    tick();
    set_sym(0, 0, 1'b1, 0);
    @(negedge clk);
    check("off1_fwd0", int'(bus.rotorB_forward_out), 1);
    bus.rotorA_forward_out = 6'd63;
    #1;
    check("off1_fwd63", int'(bus.rotorB_forward_out), 0);
    bus.encrypt = 1'b0;
    #1;
    check("noenc_fwd", int'(bus.rotorB_forward_out), 0);

    // Load aimed at another table leaves everything alone
    bus.load = 1'b1; bus.table_idx = 2'b10; bus.code_in = 6'd33;
    tick();
    bus.load = 1'b0;
    set_sym(0, 0, 1'b1, 0);
    @(negedge clk);
    check("other_idx_fwd0", int'(bus.rotorB_forward_out), 1);

    // Load coinciding with encrypt at offset 10
    do_reset();
    set_sym(0, 0, 1'b1, 2);
    repeat (5) tick();
    bus.load = 1'b1; bus.table_idx = 2'b01; bus.code_in = 6'd7;
    set_sym(4, 3, 1'b1, 3);
    @(negedge clk);
    check("ldenc_fwd4", int'(bus.rotorB_forward_out), 14);
    check("ldenc_bwd3", int'(bus.rotorB_backward_out), 57);
    tick();
    bus.load = 1'b0;
    set_sym(0, 0, 1'b1, 0);
    @(negedge clk);
    check("ldenc_after_fwd0", int'(bus.rotorB_forward_out), 7);
    bus.load = 1'b1; bus.code_in = 6'd0; bus.encrypt = 1'b0;
    tick();
    bus.load = 1'b0;
    set_sym(1, 0, 1'b1, 0);
    @(negedge clk);
    check("ldenc_next_idx1", int'(bus.rotorB_forward_out), 0);
    check("ldenc_ready", int'(bus.table_ready), 0);

    // Mid-load reset discards the partial table
    do_reset();
    set_sym(0, 0, 1'b0, 0);
    for (int i = 0; i < 30; i++) begin
      bus.load = 1'b1; bus.table_idx = 2'b01; bus.code_in = 6'((i + 1) % 64);
      tick();
    end
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    bus.load = 1'b0;
    set_sym(5, 5, 1'b1, 0);
    @(negedge clk);
    check("midrst_fwd5", int'(bus.rotorB_forward_out), 5);
    check("midrst_bwd5", int'(bus.rotorB_backward_out), 5);
    check("midrst_ready", int'(bus.table_ready), 1);
    bus.load = 1'b1; bus.code_in = 6'd9; bus.encrypt = 1'b0;
    tick();
    bus.load = 1'b0;
    set_sym(0, 9, 1'b1, 0);
    @(negedge clk);
    check("midrst_idx0_fwd", int'(bus.rotorB_forward_out), 9);
    check("midrst_idx0_bwd", int'(bus.rotorB_backward_out), 0);
    check("midrst_idx0_ready", int'(bus.table_ready), 0);

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
